// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instructions at the current PC over req/ack and
// computes the PC register's next load value.
module fetch_sequencer #(
  parameter int AW = 8,
  parameter int IW = 32,
  parameter int STEP = 1
) (
  input  logic          clock_reg,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic [AW-1:0] pc_next,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic          halt,
  output logic          halted
);
  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;
  state_t state, state_nx;
  logic outstanding, squash;
  logic [AW-1:0] addr_q;
  logic in_fetch, slot_free, ack_done, branch, deliver;
  assign in_fetch  = state == FETCH;
  assign slot_free = !instr_valid || instr_ready;
  assign ack_done  = imem_req && imem_ack;
  assign branch    = in_fetch && branch_taken;
  assign deliver   = ack_done && !squash && !branch;
  always_ff @(posedge clock_reg or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // a completion in the same cycle as halt counts as already drained
  always_comb
    state_nx = (state == IDLE) ? FETCH :
               (in_fetch && halt && (!outstanding || ack_done)) ? HALTED : state;
  always_comb begin
    imem_req  = in_fetch && (outstanding || (slot_free && !halt));
    imem_addr = outstanding ? addr_q : pc;
    pc_next   = branch ? branch_target : deliver ? pc + AW'(STEP) : pc;
    halted    = state == HALTED;
  end
  always_ff @(posedge clock_reg or negedge reset)
    if (!reset) begin
      outstanding <= 1'b0;
      squash      <= 1'b0;
      addr_q      <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      outstanding <= imem_req && !imem_ack;
      if (imem_req && !outstanding) addr_q <= pc;
      // an in-flight request across a redirect still finishes, but its data is dropped
      if (ack_done) squash <= 1'b0;
      else if (branch && imem_req) squash <= 1'b1;
      if (deliver) begin
        instr       <= imem_data;
        instr_pc    <= imem_addr;
        instr_valid <= 1'b1;
      end else if (branch || (instr_valid && instr_ready)) instr_valid <= 1'b0;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed per-cycle vectors with hand-computed outputs.
module tb_fetch_sequencer;
  logic        clock_reg = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  pc = '0;
  logic [7:0]  pc_next;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = '0;
  logic        halt = 1'b0;
  logic        halted;
  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clock_reg(clock_reg), .reset(reset), .pc(pc), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt(halt), .halted(halted)
  );

  always #5 clock_reg = ~clock_reg;
  // memory returns an address-tagged word
  assign imem_data = {24'hABCDEF, imem_addr};

  typedef struct {
    logic       rst_n;
    logic [7:0] pc;
    logic       ack;
    logic       rdy;
    logic       br;
    logic [7:0] tgt;
    logic       hlt;
    logic       req;
    logic [7:0] addr;
    logic [7:0] nxt;
    logic       vld;
    logic [7:0] ipc;
    logic       hd;
  } vec_t;

  // rst_n pc ack rdy br tgt hlt | req addr nxt | vld ipc hd
  vec_t tbl [0:20] = '{
    '{0, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0},
    '{1, 8'h00, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0},
    '{1, 8'h00, 1, 1, 0, 8'h00, 0, 1, 8'h00, 8'h01, 1, 8'h00, 0},
    '{1, 8'h01, 1, 1, 0, 8'h00, 0, 1, 8'h01, 8'h02, 1, 8'h01, 0},
    '{1, 8'h02, 1, 1, 0, 8'h00, 0, 1, 8'h02, 8'h03, 1, 8'h02, 0},
    '{1, 8'h03, 0, 1, 0, 8'h00, 0, 1, 8'h03, 8'h03, 0, 8'h00, 0},
    '{1, 8'h03, 1, 1, 0, 8'h00, 0, 1, 8'h03, 8'h04, 1, 8'h03, 0},
    '{1, 8'h04, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h04, 1, 8'h03, 0},
    '{1, 8'h04, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h04, 1, 8'h03, 0},
    '{1, 8'h04, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h04, 1, 8'h03, 0},
    '{1, 8'h04, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h04, 1, 8'h03, 0},
    '{1, 8'h04, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h04, 1, 8'h03, 0},
    '{1, 8'h04, 1, 1, 0, 8'h00, 0, 1, 8'h04, 8'h05, 1, 8'h04, 0},
    '{1, 8'h05, 0, 1, 0, 8'h00, 0, 1, 8'h05, 8'h05, 0, 8'h00, 0},
    '{1, 8'h05, 0, 1, 1, 8'h40, 0, 1, 8'h05, 8'h40, 0, 8'h00, 0},
    '{1, 8'h40, 1, 1, 0, 8'h00, 0, 1, 8'h05, 8'h40, 0, 8'h00, 0},
    '{1, 8'h40, 1, 1, 0, 8'h00, 0, 1, 8'h40, 8'h41, 1, 8'h40, 0},
    '{1, 8'h41, 1, 1, 1, 8'h80, 0, 1, 8'h41, 8'h80, 0, 8'h00, 0},
    '{1, 8'h80, 1, 1, 0, 8'h00, 0, 1, 8'h80, 8'h81, 1, 8'h80, 0},
    '{1, 8'hFF, 1, 1, 0, 8'h00, 0, 1, 8'hFF, 8'h00, 1, 8'hFF, 0},
    '{1, 8'h00, 1, 1, 0, 8'h00, 0, 1, 8'h00, 8'h01, 1, 8'h00, 0}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    @(negedge clock_reg);
    reset = v.rst_n; pc = v.pc; imem_ack = v.ack; instr_ready = v.rdy;
    branch_taken = v.br; branch_target = v.tgt; halt = v.hlt;
    #1;
    chk({tag, " imem_req"}, 32'(imem_req), 32'(v.req));
    if (v.req) chk({tag, " imem_addr"}, 32'(imem_addr), 32'(v.addr));
    chk({tag, " pc_next"}, 32'(pc_next), 32'(v.nxt));
    @(posedge clock_reg);
    #1;
    chk({tag, " instr_valid"}, 32'(instr_valid), 32'(v.vld));
    if (v.vld) begin
      chk({tag, " instr_pc"}, 32'(instr_pc), 32'(v.ipc));
      chk({tag, " instr"}, instr, {24'hABCDEF, v.ipc});
    end
    chk({tag, " halted"}, 32'(halted), 32'(v.hd));
  endtask

  initial begin
    #1;
    chk("reset instr_valid", 32'(instr_valid), 32'd0);
    chk("reset instr", instr, 32'd0);
    chk("reset instr_pc", 32'(instr_pc), 32'd0);
    for (int i = 0; i < 21; i++) run(tbl[i], $sformatf("vec%0d", i));
    // halt during an outstanding fetch, then branch attempts while halted
    run('{1, 8'h01, 0, 1, 0, 8'h00, 0, 1, 8'h01, 8'h01, 0, 8'h00, 0}, "halt0");
    run('{1, 8'h01, 0, 1, 0, 8'h00, 1, 1, 8'h01, 8'h01, 0, 8'h00, 0}, "halt1");
    run('{1, 8'h01, 1, 1, 0, 8'h00, 1, 1, 8'h01, 8'h02, 1, 8'h01, 1}, "halt2");
    run('{1, 8'h02, 1, 0, 1, 8'h33, 1, 0, 8'h00, 8'h02, 1, 8'h01, 1}, "halt3");
    run('{1, 8'h02, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h02, 0, 8'h00, 1}, "halt4");
    // reset clears halted, then a reset mid-transaction drops the request
    run('{0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0}, "rst0");
    run('{1, 8'h10, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h10, 0, 8'h00, 0}, "rst1");
    run('{1, 8'h10, 0, 1, 0, 8'h00, 0, 1, 8'h10, 8'h10, 0, 8'h00, 0}, "rst2");
    run('{0, 8'h10, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h10, 0, 8'h00, 0}, "rst3");
    run('{1, 8'h20, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h20, 0, 8'h00, 0}, "rst4");
    run('{1, 8'h20, 1, 1, 0, 8'h00, 0, 1, 8'h20, 8'h21, 1, 8'h20, 0}, "rst5");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Consumer side of the 8-bit program counter register. Reads the current PC, fetches the instruction at that address from instruction memory over a req/ack handshake, and presents it to decode through a one-entry valid/ready output register.
- Computes the PC register's next parallel-load value each cycle: hold, increment, or branch redirect. The PC register loads every clock, so this block drives the hold value explicitly.

Parameters:
- AW, 8, address width; must match the PC register width.
- IW, 32, instruction width.
- STEP, 1, PC increment per fetched instruction, modulo 2^AW.

Ports:
- clock_reg  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- pc  in  AW  current PC from the program counter register.
- pc_next  out  AW  next PC, driven to the PC register's parallel input; combinational.
- imem_req  out  1  instruction memory request.
- imem_addr  out  AW  request address; stable while a request is outstanding.
- imem_ack  in  1  memory completes the request; imem_data is valid in this cycle.
- imem_data  in  IW  fetched instruction.
- instr  out  IW  instruction to decode.
- instr_pc  out  AW  address of instr.
- instr_valid  out  1  instr/instr_pc are valid.
- instr_ready  in  1  decode accepts; a transfer occurs when instr_valid && instr_ready at a rising edge.
- branch_taken  in  1  single-cycle redirect pulse.
- branch_target  in  AW  redirect address.
- halt  in  1  level; stop fetching.
- halted  out  1  high in HALTED state.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; instr=0, instr_pc=0, instr_valid=0, halted=0. Internal outstanding=0, squash=0, addr_q=0.
- While in reset and in IDLE: imem_req=0, pc_next=pc.
- States: IDLE, FETCH, HALTED.
  - IDLE→FETCH at the first edge after reset release, giving one bubble cycle.
  - FETCH→HALTED at the first edge where halt=1 and no transaction is outstanding, counting a same-cycle completion as done.
  - HALTED persists until reset. In HALTED, branch_taken is ignored.
- slot_free = !instr_valid || instr_ready.
- imem_req in FETCH = outstanding || (slot_free && !halt).
  - Once raised, imem_req stays high until imem_ack; it never drops mid-transaction.
- imem_addr = outstanding ? addr_q : pc. On a request's first cycle with no ack, addr_q<=pc and outstanding<=1.
- An ack in the same cycle as the request's first cycle completes it (zero-latency memory). Any ack clears outstanding at the edge.
- Completion, not squashed: instr<=imem_data, instr_pc<=imem_addr, instr_valid<=1.
  - The slot is free at every ack by construction, because a request only starts when slot_free is true.
- Consumption without a new completion: instr_valid<=0.
- pc_next priority:
  1. branch_taken → branch_target.
  2. Non-squashed completion this cycle → (pc+STEP) mod 2^AW. 0xFF+1 wraps to 0x00.
  3. Otherwise → pc.
- Branch (branch_taken=1 in FETCH):
  - instr_valid<=0 at the edge, flushing the slot.
  - If imem_req=1 and imem_ack=0 this cycle, squash<=1. The outstanding request still runs to its ack, then its data is discarded and pc is not incremented. squash clears on that ack.
  - If imem_ack=1 in the same cycle as the branch, that data is discarded directly.
- A new request may start in the cycle the squashed ack arrives, using the redirected pc.
- halt rising while a transaction is outstanding: that transaction completes and is delivered normally. The instr slot keeps draining in HALTED.
- Reset mid-transaction: all state clears immediately. The memory side must tolerate imem_req dropping.

Test Plan:
- Reset, then release with pc=0x00 and imem_ack tied 1, instr_ready=1, imem_data=address-tagged → cycle 1 idle; afterwards one instruction per cycle, instr_pc=0x00,0x01,0x02…; pc_next=pc+1 each cycle.
- Memory with 2-cycle ack latency → imem_req is held high for 2 cycles with imem_addr stable; instr_valid rises the edge after ack; pc increments only in the ack cycle.
- instr_ready=0 for 5 cycles after the first delivery → instr and instr_pc are held; no new imem_req; pc_next=pc; fetch resumes the cycle ready returns.
- Branch to 0x40 while a request to 0x05 is outstanding → instr_valid drops; the 0x05 ack data is never presented; the next delivered instr_pc is 0x40.
- Branch to 0x80 in the same cycle as an ack → that data is discarded; pc_next=0x80; the next instr_pc is 0x80.
- pc=0xFF with ack → pc_next=0x00. Separately, assert halt during an outstanding fetch → that instruction is delivered, halted=1, no further imem_req, branch_taken has no effect; a later reset clears halted.
